// File: rtl/multi_mode_arbiter.sv
// N-way request arbiter with registered one-hot grant: fixed priority, round robin,
// LFSR-random and disabled modes, plus a lock that lets the current winner keep its grant.
module multi_mode_arbiter #(
    parameter int          N         = 4,
    parameter int          IDW       = $clog2(N),
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [1:0]     mode,
    input  logic [IDW-1:0] prio_sel,
    input  logic           lock,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_RR    = 2'd1,
        MODE_RAND  = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;

    localparam logic [15:0]    SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [IDW:0]   N_EXT = (IDW+1)'(N);
    localparam logic [IDW-1:0] LAST  = IDW'(N-1);

    mode_t          cur_mode;
    logic [IDW-1:0] rr_ptr;
    logic [15:0]    lfsr;
    logic           lfsr_fb;
    logic [IDW-1:0] fp_top;
    logic [IDW:0]   rnd_ext;
    logic [IDW-1:0] rnd_top;
    logic           hold;
    logic [IDW:0]   pick;
    logic           rr_load;

    // Result packs {found, index}; the top index wins outright, otherwise lowest asserted index.
    function automatic logic [IDW:0] pick_fixed(input logic [N-1:0] r, input logic [IDW-1:0] top);
        logic [IDW:0] res;
        res = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (r[IDW'(k)]) res = {1'b1, IDW'(k)};
        end
        if (r[top]) res = {1'b1, top};
        return res;
    endfunction

    // Walk downward in distance so the nearest requester after ptr is the last one kept.
    function automatic logic [IDW:0] pick_rr(input logic [N-1:0] r, input logic [IDW-1:0] ptr);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx;
        res = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IDW'((int'(ptr) + i) % N);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign cur_mode = mode_t'(mode);
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign fp_top   = ({1'b0, prio_sel} >= N_EXT) ? '0 : prio_sel;
    assign rnd_ext  = ({1'b0, lfsr[IDW-1:0]} >= N_EXT) ? ({1'b0, lfsr[IDW-1:0]} - N_EXT)
                                                        : {1'b0, lfsr[IDW-1:0]};
    assign rnd_top  = rnd_ext[IDW-1:0];
    assign hold     = lock && (cur_mode != MODE_OFF) && (|(gnt & req));

    always_comb begin
        pick    = '0;
        rr_load = 1'b0;
        case (cur_mode)
            MODE_FIXED: pick = pick_fixed(req, fp_top);
            MODE_RR: begin
                pick    = pick_rr(req, rr_ptr);
                rr_load = pick[IDW];
            end
            MODE_RAND:  pick = pick_fixed(req, rnd_top);
            default:    pick = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            rr_ptr    <= LAST;
            lfsr      <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (!hold) begin
                gnt       <= pick[IDW] ? (N'(1) << pick[IDW-1:0]) : '0;
                gnt_id    <= pick[IDW-1:0];
                gnt_valid <= pick[IDW];
                if (rr_load) rr_ptr <= pick[IDW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_arbiter.sv
// Directed bench for multi_mode_arbiter: a 4-way instance covers every mode and lock case,
// a 5-way instance covers out-of-range prio_sel handling.
module tb_multi_mode_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] mode;
    logic [1:0] prio_sel;
    logic       lock;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    logic [4:0] req5;
    logic [1:0] mode5;
    logic [2:0] prio5;
    logic       lock5;
    logic [4:0] gnt5;
    logic [2:0] gnt_id5;
    logic       gnt_valid5;

    int checks   = 0;
    int failures = 0;

    logic [15:0] modelLfsr;
    logic [3:0]  seqA [1000];
    int          hist [4];
    int          modelErr;
    int          oneHotErr;
    int          rerunDiff;

    multi_mode_arbiter #(.N(4)) dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .prio_sel(prio_sel),
        .lock(lock), .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
    );

    multi_mode_arbiter #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .mode(mode5), .prio_sel(prio5),
        .lock(lock5), .gnt(gnt5), .gnt_id(gnt_id5), .gnt_valid(gnt_valid5)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1ns after an edge and outputs are read at that same point.
    task automatic applyStimulus(input logic [3:0] r, input logic [1:0] m, input logic [1:0] p, input logic l);
        req      = r;
        mode     = m;
        prio_sel = p;
        lock     = l;
        @(posedge clk);
        #1;
    endtask

    task automatic checkGrant(input string tag, input logic [3:0] expGnt);
        logic [1:0] expId;
        expId = '0;
        for (int k = 0; k < 4; k++) if (expGnt[k]) expId = 2'(k);
        checkOutput({tag, ".gnt"}, {28'd0, gnt}, {28'd0, expGnt});
        checkOutput({tag, ".id"}, {30'd0, gnt_id}, {30'd0, expId});
        checkOutput({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, |expGnt});
    endtask

    task automatic doReset();
        rst      = 1'b1;
        req      = '0;
        mode     = '0;
        prio_sel = '0;
        lock     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic runRandom(input int pass);
        logic [1:0] m;
        logic [3:0] expGnt;
        doReset();
        modelLfsr = 16'hACE1;
        for (int i = 0; i < 1000; i++) begin
            m      = (i % 10 == 9) ? 2'd3 : 2'd2;
            expGnt = (m == 2'd3) ? 4'b0000 : (4'b0001 << modelLfsr[1:0]);
            applyStimulus(4'b1111, m, 2'd0, 1'b0);
            modelLfsr = {modelLfsr[14:0], modelLfsr[15] ^ modelLfsr[13] ^ modelLfsr[12] ^ modelLfsr[10]};
            if (gnt !== expGnt) modelErr++;
            if ((gnt & (gnt - 4'd1)) != 4'd0) oneHotErr++;
            if (pass == 0) begin
                if (gnt_valid) hist[gnt_id]++;
                seqA[i] = gnt;
            end else if (seqA[i] !== gnt) begin
                rerunDiff++;
            end
        end
    endtask

    initial begin
        int badHold;
        req5  = '0;
        mode5 = 2'd0;
        prio5 = '0;
        lock5 = 1'b0;
        doReset();
        doReset();
        checkGrant("reset", 4'b0000);

        applyStimulus(4'b1011, 2'd0, 2'd2, 1'b0); checkGrant("fixed_p2_a", 4'b0001);
        applyStimulus(4'b0111, 2'd0, 2'd2, 1'b0); checkGrant("fixed_p2_b", 4'b0100);
        applyStimulus(4'b1000, 2'd0, 2'd2, 1'b0); checkGrant("fixed_p2_c", 4'b1000);
        applyStimulus(4'b1010, 2'd0, 2'd3, 1'b0); checkGrant("fixed_p3", 4'b1000);

        // Out-of-range prio_sel on the 5-way instance must behave as prio_sel = 0.
        req5 = 5'b10110;
        prio5 = 3'd5; applyStimulus(4'b0000, 2'd0, 2'd0, 1'b0);
        checkOutput("n5_prio5", {27'd0, gnt5}, 32'h02);
        checkOutput("n5_prio5.id", {29'd0, gnt_id5}, 32'd1);
        prio5 = 3'd4; applyStimulus(4'b0000, 2'd0, 2'd0, 1'b0);
        checkOutput("n5_prio4", {27'd0, gnt5}, 32'h10);
        checkOutput("n5_prio4.id", {29'd0, gnt_id5}, 32'd4);
        prio5 = 3'd7; applyStimulus(4'b0000, 2'd0, 2'd0, 1'b0);
        checkOutput("n5_prio7", {27'd0, gnt5}, 32'h02);
        prio5 = 3'd2; applyStimulus(4'b0000, 2'd0, 2'd0, 1'b0);
        checkOutput("n5_prio2", {27'd0, gnt5}, 32'h04);
        req5 = '0;

        doReset();
        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("rr_1", 4'b0001);
        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("rr_2", 4'b0010);
        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("rr_3", 4'b0100);
        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("rr_4", 4'b1000);
        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("rr_wrap", 4'b0001);
        applyStimulus(4'b1010, 2'd1, 2'd0, 1'b0); checkGrant("rr_sparse_1", 4'b0010);
        applyStimulus(4'b1010, 2'd1, 2'd0, 1'b0); checkGrant("rr_sparse_2", 4'b1000);
        applyStimulus(4'b1010, 2'd1, 2'd0, 1'b0); checkGrant("rr_sparse_3", 4'b0010);

        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("rr_pre_reset", 4'b0100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkGrant("mid_reset", 4'b0000);
        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("rr_after_reset", 4'b0001);

        applyStimulus(4'b0010, 2'd0, 2'd0, 1'b0); checkGrant("lock_setup", 4'b0010);
        badHold = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0011, 2'd0, 2'd0, 1'b1);
            if (gnt !== 4'b0010) badHold++;
        end
        checkOutput("lock_hold_3cyc", badHold, 0);
        applyStimulus(4'b0001, 2'd0, 2'd0, 1'b1); checkGrant("lock_req_drop", 4'b0001);
        applyStimulus(4'b0011, 2'd1, 2'd0, 1'b1); checkGrant("lock_over_mode", 4'b0001);
        applyStimulus(4'b0011, 2'd3, 2'd0, 1'b1); checkGrant("lock_mode3", 4'b0000);
        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("rr_ptr_kept", 4'b0010);

        applyStimulus(4'b0000, 2'd0, 2'd0, 1'b0); checkGrant("zero_m0", 4'b0000);
        applyStimulus(4'b0000, 2'd1, 2'd0, 1'b0); checkGrant("zero_m1", 4'b0000);
        applyStimulus(4'b0000, 2'd2, 2'd0, 1'b0); checkGrant("zero_m2", 4'b0000);
        applyStimulus(4'b1111, 2'd1, 2'd0, 1'b0); checkGrant("zero_rr_ptr", 4'b0100);

        applyStimulus(4'b0101, 2'd0, 2'd0, 1'b1); checkGrant("lock_hold_b", 4'b0100);
        applyStimulus(4'b0101, 2'd0, 2'd0, 1'b0); checkGrant("lock_release", 4'b0001);

        for (int k = 0; k < 4; k++) hist[k] = 0;
        modelErr  = 0;
        oneHotErr = 0;
        rerunDiff = 0;
        runRandom(0);
        runRandom(1);
        checkOutput("rand_model", modelErr, 0);
        checkOutput("rand_onehot", oneHotErr, 0);
        checkOutput("rand_rerun", rerunDiff, 0);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("rand_hist%0d", k), {31'd0, hist[k] >= 150}, 32'd1);

        badHold = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0100, 2'd2, 2'd0, 1'b0);
            if (gnt !== 4'b0100 || gnt_id !== 2'd2) badHold++;
        end
        checkOutput("rand_single_req", badHold, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_mode_arbiter.md
# multi_mode_arbiter

Parametrised N-way request arbiter with a registered one-hot grant. It supports four modes: fixed priority with a selectable top requester, round robin, LFSR-random and disabled. A lock handshake lets the current winner hold its grant across cycles. This is the next-generation arbiter for the shared-resource paths, replacing fixed 4-way arbitration with a configurable width and grant locking.

## Interface
- N, default 4: number of requesters, legal range 2..16.
- IDW, default $clog2(N): width of index fields.
- LFSR_SEED, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- clk  input  1  sole clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- req  input  N  request vector; bit k is requester k.
- mode  input  2  0 = fixed priority, 1 = round robin, 2 = random, 3 = disabled.
- prio_sel  input  IDW  top-priority index for mode 0. A value >= N is treated as 0.
- lock  input  1  holds the current grant (see Operation).
- gnt  output  N  registered grant, one-hot or zero.
- gnt_id  output  IDW  index of the set gnt bit; 0 when gnt == 0.
- gnt_valid  output  1  |gnt.

## Operation
- Registered state:
  - gnt.
  - rr_ptr (IDW bits): last round-robin winner.
  - lfsr (16 bits): Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
- On every edge with rst=0, the grant is recomputed from the current req/mode/prio_sel/lock, and lfsr advances one step regardless of mode.
- Lock check, evaluated first: if lock=1, gnt[k]=1 and req[k]=1, then gnt is unchanged and rr_ptr is unchanged. This applies in modes 0-2 and overrides any mode change. Mode 3 overrides lock.
- Mode 0, fixed priority: the order is prio_sel first, then indices 0..N-1 ascending with prio_sel skipped. The first asserted req wins. Example with prio_sel=2: order is 2,0,1,3.
- Mode 1, round robin: search starts at rr_ptr+1 (mod N) and wraps. The first asserted req wins. rr_ptr loads the winner index only when a round-robin grant is issued.
- Mode 2, random: the top index is t = lfsr[IDW-1:0], reduced to t-N when t >= N. The priority order is then as in mode 0 with t as the top.
- Mode 3, disabled: gnt=0. rr_ptr and lfsr keep their behaviour.
- No request asserted (req == 0): gnt=0 in every mode.
- A grant is never issued to a deasserted req. gnt is always one-hot or zero.
- rr_ptr is not modified by grants in modes 0 and 2, or by locked holds.

## Timing
- Latency: req/mode/prio_sel/lock sampled at edge t are reflected in gnt after edge t, i.e. one cycle.
- gnt_id and gnt_valid are registered alongside gnt, on the same cycle, with no combinational path from inputs.
- Reset: rst sampled high at an edge sets gnt=0, gnt_id=0, gnt_valid=0, rr_ptr=N-1 (so index 0 is next in round robin) and lfsr=LFSR_SEED.
- Reset mid-operation: any held or locked grant drops at that edge. Arbitration resumes on the first edge with rst=0.
- Lock release: when lock falls, or req[k] falls while lock is high, normal arbitration applies on that same edge, so the grant can move in one cycle.
- Mode changes take effect on the edge at which they are sampled. There is no pipeline flush and no dead cycle.
- Wrap-around: with rr_ptr=N-1 the search starts at index 0.

## Test plan
- Fixed priority, N=4, mode=0, prio_sel=2:
  - req=4'b1011 -> next cycle gnt=4'b0001, gnt_id=0.
  - req=4'b0111 -> gnt=4'b0100.
  - prio_sel=5 (out of range, IDW=2 aliasing not applicable at N=4; use N=5 build): behaves as prio_sel=0.
- Round robin from reset, mode=1, req=4'b1111 held 5 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001. Then req=4'b1010 -> 0010, 1000, 0010.
- Lock, mode=0, prio_sel=0:
  - req=4'b0010 -> gnt=0010.
  - Then req=4'b0011 with lock=1 -> gnt stays 0010 for 3 cycles.
  - Drop req[1] -> next cycle gnt=0001.
  - Repeat with mode=3 while locked -> gnt=0 next cycle.
- Random, mode=2, req=4'b1111 for 1000 cycles -> gnt always one-hot, each index granted at least 150 times, sequence identical across two runs with the same LFSR_SEED. With req=4'b0100 -> gnt=0100 every cycle.
- Reset mid-operation: rst=1 for one edge while gnt=0100 in mode 1 -> gnt=0, gnt_valid=0 after that edge. With req=4'b1111 afterwards, the first grant is 0001.
- Zero request: req=0 in each of modes 0-2 -> gnt=0, gnt_valid=0, gnt_id=0, rr_ptr unchanged.
